// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 codes, FSM states,
// memory word-index width and the access-size lane mask helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_WORD_W = 14;

  typedef enum logic {
    IDLE,
    SPLIT2
  } lsu_state_e;

  // Lane mask for the access size, before shifting by the byte offset.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) begin
      funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
    end
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed bytes out of a 64-bit
// two-word window and applies RV32 size/sign extension.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data_in,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data_out
);

  logic [31:0] shifted;

  assign shifted = 32'(data_in >> {offset, 3'b000});

  always_comb begin
    data_out = shifted;
    case (funct3)
      F3_B:    data_out = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_out = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_out = {24'd0, shifted[7:0]};
      F3_HU:   data_out = {16'd0, shifted[15:0]};
      default: data_out = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RV32 byte/half/word requests into
// byte-enabled word accesses, splitting word-crossing accesses in two beats.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic MISALIGNED_EN = 1'b1,
  parameter int   MEM_ADDR_W    = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [31:0]           load_data,
  output logic                  access_err,
  output logic                  mem_we,
  output logic [3:0]            mem_byte_en,
  output logic [MEM_ADDR_W-1:0] mem_write_addr,
  output logic [MEM_ADDR_W-1:0] mem_read_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  lsu_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic        split_q, split_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] lo_word_q, lo_word_d;
  logic        err_q, err_d;

  logic [1:0]            offset;
  logic [7:0]            lanes;
  logic [63:0]           wdata_wide;
  logic [MEM_WORD_W-1:0] word_lo, word_hi, word_sel;
  logic                  legal, crossing;
  logic                  we_c, stall_c;
  logic [3:0]            be_c;
  logic [31:0]           wd_c;
  logic [15:0]           byte_addr;
  logic [63:0]           align_in;
  logic [31:0]           align_out;
  logic                  unused_addr_hi;

  assign offset     = req_addr[1:0];
  assign lanes      = {4'b0000, size_mask(req_funct3)} << offset;
  assign wdata_wide = {32'd0, req_wdata} << {offset, 3'b000};
  assign word_lo    = req_addr[15:2];
  assign word_hi    = word_lo + 14'd1;  // wraps from 0x3FFF to 0x0000
  assign legal      = funct3_legal(req_store, req_funct3);
  assign crossing   = |lanes[7:4];
  assign unused_addr_hi = ^req_addr[31:16];

  always_comb begin
    state_d   = state_q;
    pend_d    = 1'b0;
    split_d   = 1'b0;
    off_d     = off_q;
    f3_d      = f3_q;
    lo_word_d = lo_word_q;
    err_d     = 1'b0;
    we_c      = 1'b0;
    be_c      = 4'b0000;
    stall_c   = 1'b0;
    word_sel  = word_lo;
    wd_c      = wdata_wide[31:0];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal || (crossing && !MISALIGNED_EN)) begin
            err_d = 1'b1;
          end else begin
            we_c  = req_store;
            be_c  = lanes[3:0];
            off_d = offset;
            f3_d  = req_funct3;
            if (crossing) begin
              stall_c = 1'b1;
              state_d = SPLIT2;
            end else begin
              pend_d = !req_store;
            end
          end
        end
      end
      SPLIT2: begin
        // Second beat of the held request; the word-W read data arrives now.
        we_c     = req_store;
        be_c     = lanes[7:4];
        word_sel = word_hi;
        wd_c     = wdata_wide[63:32];
        pend_d   = !req_store;
        split_d  = !req_store;
        if (!req_store) begin
          lo_word_d = mem_read_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      split_q   <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      lo_word_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      split_q   <= split_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      lo_word_q <= lo_word_d;
      err_q     <= err_d;
    end
  end

  assign align_in = split_q ? {mem_read_data, lo_word_q} : {32'd0, mem_read_data};

  lsu_load_align u_align (
    .data_in  (align_in),
    .offset   (off_q),
    .funct3   (f3_q),
    .data_out (align_out)
  );

  // Issue-side outputs are gated so a held request cannot reach memory in reset.
  assign stall          = stall_c & rst_n;
  assign mem_we         = we_c & rst_n;
  assign mem_byte_en    = rst_n ? be_c : 4'b0000;
  assign byte_addr      = {word_sel, 2'b00};
  assign mem_read_addr  = MEM_ADDR_W'(byte_addr);
  assign mem_write_addr = MEM_ADDR_W'(byte_addr);
  assign mem_write_data = wd_c;
  assign load_valid     = pend_q;
  assign load_data      = pend_q ? align_out : 32'd0;
  assign access_err     = err_q;

endmodule
